// File: rtl/dot_tracker_if.sv
// Bus between the maze tilemap source, the dot tracker and its consumers
// (renderer, score display, ghost logic).
interface dot_tracker_if #(
  parameter int COLS = 32,
  parameter int ROWS = 24
);
  localparam int N = COLS * ROWS;

  logic [N-1:0] init_dots;
  logic [N-1:0] init_big_dots;
  logic [4:0]   pac_col;
  logic [4:0]   pac_row;
  logic         pac_valid;
  logic         tick_en;

  logic [N-1:0] tilemap_dots;
  logic [N-1:0] tilemap_big_dots;
  logic [15:0]  score;
  logic [9:0]   dots_left;
  logic         eat_dot;
  logic         eat_big;
  logic         power_active;
  logic [8:0]   power_remaining;
  logic         ready;
  logic         level_clear;

  modport master (
    output init_dots, init_big_dots, pac_col, pac_row, pac_valid, tick_en,
    input  tilemap_dots, tilemap_big_dots, score, dots_left, eat_dot, eat_big,
           power_active, power_remaining, ready, level_clear
  );

  modport slave (
    input  init_dots, init_big_dots, pac_col, pac_row, pac_valid, tick_en,
    output tilemap_dots, tilemap_big_dots, score, dots_left, eat_dot, eat_big,
           power_active, power_remaining, ready, level_clear
  );
endinterface

// File: rtl/dot_tracker.sv
// Live dot/big-dot maps, score, remaining-dot count and frightened timer.
//   state | meaning
//   COUNT | walk the snapshotted maps one tile per cycle, tally dots_left
//   RUN   | accept Pac-Man tile entries, eat dots, run power timer
//   CLEAR | level done; maps/score frozen, power timer still drains
module dot_tracker #(
  parameter int COLS        = 32,
  parameter int ROWS        = 24,
  parameter int DOT_PTS     = 10,
  parameter int BIG_PTS     = 50,
  parameter int POWER_TICKS = 360
) (
  input  logic          clk,
  input  logic          reset,
  dot_tracker_if.slave  bus
);
  localparam int N  = COLS * ROWS;
  localparam int IW = 10;

  typedef enum logic [1:0] {COUNT, RUN, CLEAR} state_t;

  state_t        state;
  logic [N-1:0]  dots_q;
  logic [N-1:0]  big_q;
  logic [IW-1:0] idx;
  logic [15:0]   score_q;
  logic [9:0]    left_q;
  logic [8:0]    pow_q;
  logic          eat_dot_q;
  logic          eat_big_q;
  logic          pow_act_q;
  logic          ready_q;
  logic          clear_q;

  logic [IW-1:0] k_raw;
  logic [IW-1:0] k;
  logic          in_range;
  logic          cnt_hit;
  logic          take_big;
  logic          take_dot;
  logic [16:0]   score_big;
  logic [16:0]   score_dot;

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

  always_comb begin
    k_raw     = IW'(bus.pac_row) * IW'(COLS) + IW'(bus.pac_col);
    in_range  = (int'(bus.pac_col) < COLS) && (int'(bus.pac_row) < ROWS);
    // out-of-range coordinates can alias past the map end; park them on 0
    k         = in_range ? k_raw : '0;
    cnt_hit   = dots_q[idx] | big_q[idx];
    take_big  = (state == RUN) && bus.pac_valid && in_range && big_q[k];
    take_dot  = (state == RUN) && bus.pac_valid && in_range && !big_q[k] && dots_q[k];
    score_big = {1'b0, score_q} + 17'(BIG_PTS);
    score_dot = {1'b0, score_q} + 17'(DOT_PTS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dots_q    <= bus.init_dots;
      big_q     <= bus.init_big_dots;
      idx       <= '0;
      score_q   <= '0;
      left_q    <= '0;
      pow_q     <= '0;
      eat_dot_q <= 1'b0;
      eat_big_q <= 1'b0;
      pow_act_q <= 1'b0;
      ready_q   <= 1'b0;
      clear_q   <= 1'b0;
      state     <= COUNT;
    end else begin
      eat_dot_q <= 1'b0;
      eat_big_q <= 1'b0;

      case (state)
        COUNT: begin
          if (cnt_hit) left_q <= left_q + 10'd1;
          if (idx == IW'(N - 1)) begin
            if (cnt_hit || left_q != '0) begin
              state   <= RUN;
              ready_q <= 1'b1;
            end else begin
              state   <= CLEAR;
              clear_q <= 1'b1;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end

        RUN: begin
          if (take_big) begin
            big_q[k]  <= 1'b0;
            dots_q[k] <= 1'b0;
            score_q   <= sat16(score_big);
            left_q    <= left_q - 10'd1;
            eat_big_q <= 1'b1;
          end else if (take_dot) begin
            dots_q[k] <= 1'b0;
            score_q   <= sat16(score_dot);
            left_q    <= left_q - 10'd1;
            eat_dot_q <= 1'b1;
          end
          if ((take_big || take_dot) && left_q == 10'd1) begin
            state   <= CLEAR;
            ready_q <= 1'b0;
            clear_q <= 1'b1;
          end
        end

        CLEAR: begin
          clear_q <= 1'b1;
          ready_q <= 1'b0;
        end

        default: state <= COUNT;
      endcase

      // a big-dot eat reloads the timer and suppresses that cycle's tick
      if (take_big) begin
        pow_q     <= 9'(POWER_TICKS);
        pow_act_q <= 1'b1;
      end else if (state != COUNT && bus.tick_en && pow_q != '0) begin
        pow_q     <= pow_q - 9'd1;
        pow_act_q <= (pow_q != 9'd1);
      end
    end
  end

  assign bus.tilemap_dots     = dots_q;
  assign bus.tilemap_big_dots = big_q;
  assign bus.score            = score_q;
  assign bus.dots_left        = left_q;
  assign bus.eat_dot          = eat_dot_q;
  assign bus.eat_big          = eat_big_q;
  assign bus.power_active     = pow_act_q;
  assign bus.power_remaining  = pow_q;
  assign bus.ready            = ready_q;
  assign bus.level_clear      = clear_q;
endmodule

// File: tb/tb_dot_tracker.sv
// Self-checking bench for dot_tracker: directed table, hand sequences for
// timer/reset/saturation corners, and randomized play against a map model.
module tb_dot_tracker;
  localparam int COLS = 32;
  localparam int ROWS = 24;
  localparam int N    = COLS * ROWS;
  localparam int PT   = 360;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  dot_tracker_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
  dot_tracker_if #(.COLS(COLS), .ROWS(ROWS)) bus2 ();

  dot_tracker #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  dot_tracker #(.COLS(COLS), .ROWS(ROWS), .BIG_PTS(100)) dut2 (
    .clk(clk), .reset(reset2), .bus(bus2.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: plain maps and counters
  bit [N-1:0] md, mb;
  int  mscore, mleft, mpow;
  bit  mrun, mclr, exp_ed, exp_eb;

  typedef struct {
    bit pv; int col; int row; bit tick;
    int score; int left; bit ed; bit eb; int pow; bit clr; bit rdy;
  } vec_t;
  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_map(input string nm, input bit [N-1:0] act, input bit [N-1:0] exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_cycle(input bit pv, input int col, input int row, input bit tick);
    int k;
    exp_ed = 0;
    exp_eb = 0;
    if (mrun && pv && col < COLS && row < ROWS) begin
      k = row * COLS + col;
      if (mb[k]) begin
        mb[k] = 0; md[k] = 0;
        mscore = sat(mscore + 50); mleft--; exp_eb = 1; mpow = PT;
      end else if (md[k]) begin
        md[k] = 0;
        mscore = sat(mscore + 10); mleft--; exp_ed = 1;
      end
    end
    if (!exp_eb && tick && mpow > 0) mpow--;
    if (mrun && mleft == 0) begin mrun = 0; mclr = 1; end
  endtask

  task automatic apply(input bit pv, input int col, input int row, input bit tick);
    bus.pac_valid = pv;
    bus.pac_col   = 5'(col);
    bus.pac_row   = 5'(row);
    bus.tick_en   = tick;
    step();
    model_cycle(pv, col, row, tick);
    bus.pac_valid = 0;
    bus.tick_en   = 0;
  endtask

  task automatic check_all(input string t);
    chk({t, "/score"}, bus.score, mscore);
    chk({t, "/dots_left"}, bus.dots_left, mleft);
    chk({t, "/eat_dot"}, bus.eat_dot, exp_ed);
    chk({t, "/eat_big"}, bus.eat_big, exp_eb);
    chk({t, "/power_remaining"}, bus.power_remaining, mpow);
    chk({t, "/power_active"}, bus.power_active, (mpow != 0));
    chk({t, "/ready"}, bus.ready, mrun);
    chk({t, "/level_clear"}, bus.level_clear, mclr);
    chk_map({t, "/dots_map"}, bus.tilemap_dots, md);
    chk_map({t, "/big_map"}, bus.tilemap_big_dots, mb);
  endtask

  task automatic do_reset(input bit [N-1:0] d, input bit [N-1:0] b);
    int n;
    bus.init_dots = d;
    bus.init_big_dots = b;
    bus.pac_valid = 0;
    bus.tick_en = 0;
    reset = 1;
    step();
    step();
    chk("rst/score", bus.score, 0);
    chk("rst/dots_left", bus.dots_left, 0);
    chk("rst/power_remaining", bus.power_remaining, 0);
    chk("rst/ready", bus.ready, 0);
    chk("rst/level_clear", bus.level_clear, 0);
    chk_map("rst/dots_map", bus.tilemap_dots, d);
    chk_map("rst/big_map", bus.tilemap_big_dots, b);
    md = d; mb = b; mscore = 0; mpow = 0; exp_ed = 0; exp_eb = 0;
    mleft = $countones(d | b);
    reset = 0;
    n = 0;
    // pac_valid / tick_en activity during the count must be ignored
    while (n < 1000 && !bus.ready && !bus.level_clear) begin
      bus.pac_valid = 1'($urandom_range(0, 1));
      bus.tick_en   = 1'($urandom_range(0, 1));
      bus.pac_col   = 5'($urandom_range(0, 31));
      bus.pac_row   = 5'($urandom_range(0, 23));
      step();
      n++;
    end
    bus.pac_valid = 0;
    bus.tick_en = 0;
    chk("count_cycles", n, N);
    mrun = (mleft > 0);
    mclr = !mrun;
    check_all("after_count");
  endtask

  initial begin
    bit [N-1:0] d, b, mask;
    int n, eats;

    bus.init_dots = '0; bus.init_big_dots = '0;
    bus.pac_col = '0; bus.pac_row = '0; bus.pac_valid = 0; bus.tick_en = 0;
    bus2.init_dots = '0; bus2.init_big_dots = '1;
    bus2.pac_col = '0; bus2.pac_row = '0; bus2.pac_valid = 0; bus2.tick_en = 0;

    tbl[0] = '{1, 1, 1, 0, 10, 2, 1, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 0, 0, 10, 2, 0, 0, 0, 0, 1};
    tbl[2] = '{1, 1, 1, 0, 10, 2, 0, 0, 0, 0, 1};
    tbl[3] = '{1, 31, 30, 0, 10, 2, 0, 0, 0, 0, 1};
    tbl[4] = '{1, 1, 2, 0, 60, 1, 0, 1, 360, 0, 1};
    tbl[5] = '{0, 0, 0, 1, 60, 1, 0, 0, 359, 0, 1};
    tbl[6] = '{1, 1, 2, 1, 60, 1, 0, 0, 358, 0, 1};

    // directed walk: dots at 33, 34; big dot at 65
    d = '0; b = '0;
    d[33] = 1; d[34] = 1; b[65] = 1;
    do_reset(d, b);
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].pv, tbl[i].col, tbl[i].row, tbl[i].tick);
      chk($sformatf("tbl%0d/score", i), bus.score, tbl[i].score);
      chk($sformatf("tbl%0d/dots_left", i), bus.dots_left, tbl[i].left);
      chk($sformatf("tbl%0d/eat_dot", i), bus.eat_dot, tbl[i].ed);
      chk($sformatf("tbl%0d/eat_big", i), bus.eat_big, tbl[i].eb);
      chk($sformatf("tbl%0d/power_remaining", i), bus.power_remaining, tbl[i].pow);
      chk($sformatf("tbl%0d/level_clear", i), bus.level_clear, tbl[i].clr);
      chk($sformatf("tbl%0d/ready", i), bus.ready, tbl[i].rdy);
      chk_map($sformatf("tbl%0d/dots_map", i), bus.tilemap_dots, md);
      chk_map($sformatf("tbl%0d/big_map", i), bus.tilemap_big_dots, mb);
    end
    repeat (358) apply(0, 0, 0, 1);
    chk("power_expired/remaining", bus.power_remaining, 0);
    chk("power_expired/active", bus.power_active, 0);
    apply(0, 0, 0, 1);
    check_all("power_floor");
    apply(1, 2, 1, 0);
    chk("final_eat/dots_left", bus.dots_left, 0);
    chk("final_eat/level_clear", bus.level_clear, 1);
    chk("final_eat/ready", bus.ready, 0);
    chk("final_eat/eat_dot", bus.eat_dot, 1);
    check_all("final_eat");
    apply(1, 1, 1, 1);
    chk("clear_frozen/score", bus.score, 70);
    check_all("clear_frozen");

    // big eat coinciding with tick reloads to the full duration
    d = '0; b = '0;
    b[0] = 1; b[1] = 1; d[5] = 1;
    do_reset(d, b);
    apply(1, 0, 0, 0);
    chk("big0/power_remaining", bus.power_remaining, PT);
    repeat (5) apply(0, 0, 0, 1);
    chk("ticks5/power_remaining", bus.power_remaining, PT - 5);
    apply(1, 1, 0, 1);
    chk("big_tick/power_remaining", bus.power_remaining, PT);
    check_all("big_tick");
    repeat (3) apply(0, 0, 0, 1);
    check_all("big_tick_after");

    // empty level goes straight to CLEAR
    do_reset('0, '0);
    chk("empty/level_clear", bus.level_clear, 1);
    repeat (4) apply(1, 3, 3, 1);
    chk("empty/ready", bus.ready, 0);
    check_all("empty");

    // reset in the middle of COUNT restarts from index 0
    for (int i = 0; i < N; i++) begin
      d[i] = ($urandom_range(0, 3) == 0);
      b[i] = ($urandom_range(0, 9) == 0);
    end
    bus.init_dots = d; bus.init_big_dots = b;
    reset = 1;
    step();
    reset = 0;
    repeat (300) step();
    mask = '0;
    for (int i = 0; i < 300; i++) mask[i] = 1;
    chk("partial_count/dots_left", bus.dots_left, $countones((d | b) & mask));
    d = '0; b = '0;
    d[100] = 1; b[767] = 1;
    do_reset(d, b);
    apply(31, 23, 0, 0);
    apply(1, 31, 23, 0);
    check_all("last_tile_big");

    // randomized play on a small populated area; first run is cut short by reset
    for (int run = 0; run < 2; run++) begin
      d = '0; b = '0;
      for (int i = 0; i < 64; i++) begin
        n = $urandom_range(0, 7);
        if (n == 0) b[i] = 1;
        else if (n < 3) d[i] = 1;
      end
      d[7] = 1;
      do_reset(d, b);
      for (int c = 0; c < ((run == 0) ? 200 : 3000); c++) begin
        apply(1'($urandom_range(0, 1)), $urandom_range(0, 31),
              ($urandom_range(0, 9) == 0) ? $urandom_range(24, 31) : $urandom_range(0, 2),
              1'($urandom_range(0, 3) == 0));
        check_all($sformatf("rnd%0d_%0d", run, c));
      end
    end
    chk("rnd/level_clear_reached", bus.level_clear, 1);

    // saturation on a second instance with 100-point big dots
    reset = 1;
    step();
    reset2 = 0;
    n = 0;
    while (n < 1000 && !bus2.ready) begin step(); n++; end
    chk("sat/count_cycles", n, N);
    chk("sat/dots_left", bus2.dots_left, N);
    for (int e = 0; e < 1400; e++) begin
      bus2.pac_col = 5'((e % N) % COLS);
      bus2.pac_row = 5'((e % N) / COLS);
      bus2.pac_valid = 1;
      step();
      bus2.pac_valid = 0;
      eats = (e + 1 > N) ? N : e + 1;
      if (e == 654 || e == 655 || e == 700 || e == 1399)
        chk($sformatf("sat/score_e%0d", e), bus2.score, sat(eats * 100));
    end
    chk("sat/level_clear", bus2.level_clear, 1);
    chk("sat/dots_left_end", bus2.dots_left, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
